// File: rtl/mvm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mvm_pkg
// Description : Shared types and default system constants for the UART MVM
//               output stage. Holds the transmitter state type, the default
//               sizing of the result bus and UART framing, and a helper that
//               sizes counters.
// Revision    : 1.0  initial release
// ============================================================================
package mvm_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   localparam int CLOCKS_PER_PULSE = 4;   // clk cycles per UART bit
   localparam int BITS_PER_WORD    = 8;   // data bits per packet
   localparam int PACKET_SIZE_TX   = 13;  // bits per packet incl. start
   localparam int R                = 4;   // result elements on the bus
   localparam int W_Y_OUT          = 8;   // width of each result element

   // Width of a counter spanning 0..range_n-1, never less than one bit.
   function automatic int cnt_width(input int range_n);
      return (range_n > 1) ? $clog2(range_n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mvm_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Interface   : mvm_uart_tx_if
// Description : Valid/ready result-bus handshake between the MVM core
//               (master) and the UART transmitter (slave).
//   s_valid  master->slave  result bus valid
//   s_ready  slave->master  transmitter idle, bus can be accepted
//   s_data   master->slave  W_BUS-bit result bus
// Revision    : 1.0  initial release
// ============================================================================
interface mvm_uart_tx_if #(
   parameter int W_BUS = mvm_pkg::R * mvm_pkg::W_Y_OUT
) ();

   logic             s_valid;
   logic             s_ready;
   logic [W_BUS-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);

endinterface
`default_nettype wire

// File: rtl/mvm_uart_tx_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Bit-period pulse counter. Counts 0..CLOCKS_PER_PULSE-1 while
//               enabled and raises tick during the last cycle of each bit.
//   clk   in   system clock
//   rstn  in   asynchronous active-low reset
//   en    in   count enable
//   clr   in   synchronous clear (has priority over en)
//   tick  out  last cycle of the current bit period
// Revision    : 1.0  initial release
// ============================================================================
module uart_baud_tick #(
   parameter int CLOCKS_PER_PULSE = mvm_pkg::CLOCKS_PER_PULSE
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   input  logic clr,
   output logic tick
);
   import mvm_pkg::*;

   localparam int               CNT_W    = cnt_width(CLOCKS_PER_PULSE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // With CLOCKS_PER_PULSE=1 the counter sits at 0 and ticks every cycle.
   assign tick = en && (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mvm_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mvm_uart_tx
// Description : UART output stage of the MVM system. Accepts the whole result
//               bus in one valid/ready handshake and serialises it as N_WORDS
//               UART packets, word 0 first. Each packet is a start bit (0),
//               BITS_PER_WORD data bits LSB-first, then high stop/padding bits
//               up to PACKET_SIZE_TX bits.
//   clk   in   system clock
//   rstn  in   asynchronous active-low reset
//   s_if  slave  result bus handshake (s_valid, s_ready, s_data)
//   tx    out  UART serial line, idle high, registered
// Revision    : 1.0  initial release
// ============================================================================
module mvm_uart_tx #(
   parameter int CLOCKS_PER_PULSE = mvm_pkg::CLOCKS_PER_PULSE,
   parameter int BITS_PER_WORD    = mvm_pkg::BITS_PER_WORD,
   parameter int PACKET_SIZE_TX   = mvm_pkg::PACKET_SIZE_TX,
   parameter int R                = mvm_pkg::R,
   parameter int W_Y_OUT          = mvm_pkg::W_Y_OUT
) (
   input  logic        clk,
   input  logic        rstn,
   mvm_uart_tx_if.slave s_if,
   output logic        tx
);
   import mvm_pkg::*;

   localparam int W_BUS     = R * W_Y_OUT;
   localparam int N_WORDS   = W_BUS / BITS_PER_WORD;
   localparam int BIT_W     = cnt_width(PACKET_SIZE_TX);
   localparam int WORD_W    = cnt_width(N_WORDS);
   localparam int BUF_IDX_W = cnt_width(W_BUS);

   localparam logic [BIT_W-1:0]  BIT_LAST     = BIT_W'(PACKET_SIZE_TX - 1);
   localparam logic [BIT_W-1:0]  BIT_DATA_END = BIT_W'(BITS_PER_WORD);
   localparam logic [WORD_W-1:0] WORD_LAST    = WORD_W'(N_WORDS - 1);

   state_e              state_q,  state_d;
   logic [W_BUS-1:0]    buf_q,    buf_d;
   logic [BIT_W-1:0]    bit_q,    bit_d;
   logic [WORD_W-1:0]   word_q,   word_d;
   logic                tx_q,     tx_d;

   logic                baud_en;
   logic                baud_clr;
   logic                baud_tick;
   logic [BUF_IDX_W-1:0] buf_idx;

   uart_baud_tick #(
      .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE)
   ) u_baud (
      .clk  (clk),
      .rstn (rstn),
      .en   (baud_en),
      .clr  (baud_clr),
      .tick (baud_tick)
   );

   assign baud_en     = (state_q == SEND);
   assign s_if.s_ready = (state_q == IDLE);
   assign tx          = tx_q;

   // Buffer position of data bit bit_q of the current word; tx_d computed on a
   // tick is the value for bit_q+1, which for data bits is data[bit_q].
   // Only consumed while bit_q < BITS_PER_WORD.
   assign buf_idx = BUF_IDX_W'(int'(word_q) * BITS_PER_WORD + int'(bit_q));

   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      bit_d    = bit_q;
      word_d   = word_q;
      tx_d     = tx_q;
      baud_clr = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (s_if.s_valid) begin
               buf_d    = s_if.s_data;
               bit_d    = '0;
               word_d   = '0;
               baud_clr = 1'b1;
               tx_d     = 1'b0;     // start bit of word 0 shows at H+1
               state_d  = SEND;
            end
         end
         SEND: begin
            if (baud_tick) begin
               if (bit_q == BIT_LAST) begin
                  bit_d = '0;
                  if (word_q == WORD_LAST) begin
                     word_d  = '0;
                     tx_d    = 1'b1;
                     state_d = IDLE;
                  end else begin
                     word_d = word_q + 1'b1;
                     tx_d   = 1'b0;  // next start bit, back-to-back
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
                  tx_d  = (bit_q < BIT_DATA_END) ? buf_q[buf_idx] : 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         buf_q   <= '0;
         bit_q   <= '0;
         word_q  <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         bit_q   <= bit_d;
         word_q  <= word_d;
         tx_q    <= tx_d;
      end
   end

endmodule
`default_nettype wire
